fifo_uart_drain: RTL and testbench
==================================

FIFO_UART_DRAIN -- requirements
Module: fifo_uart_drain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the FIFO read data width and the number of serial data bits per frame.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 217, giving i_clk cycles per serial bit; legal range 4..65535.
REQ-003 The module SHALL have parameter TIMEOUT, default 4, giving the maximum i_clk cycles to wait for i_rd_dv after a read request.
REQ-004 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port i_enable, input, 1 bit: high permits new FIFO reads.
REQ-007 The module SHALL have port i_empty, input, 1 bit: FIFO empty flag.
REQ-008 The module SHALL have port o_rd_en, output, 1 bit: registered FIFO read request, one-cycle pulse.
REQ-009 The module SHALL have port i_rd_dv, input, 1 bit: FIFO read data valid.
REQ-010 The module SHALL have port i_rd_data, input, WIDTH bits: FIFO read data.
REQ-011 The module SHALL have port o_tx_serial, output, 1 bit: UART line, idle high.
REQ-012 The module SHALL have port o_tx_active, output, 1 bit: high from start bit through stop bit.
REQ-013 The module SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at the end of the stop bit.
REQ-014 The module SHALL have port o_err, output, 1 bit: one-cycle pulse on read timeout.
REQ-015 The module SHALL have port o_word_count, output, 16 bits: count of frames completed.

Function
REQ-016 The FSM SHALL have five states: IDLE, RD_WAIT, START, DATA, STOP.
REQ-017 IDLE: when i_enable=1 and i_empty=0, the FSM SHALL register o_rd_en=1 for exactly one cycle and enter RD_WAIT.
REQ-018 RD_WAIT: on the first cycle with i_rd_dv=1, the FSM SHALL capture i_rd_data into a shift register and enter START.
REQ-019 RD_WAIT: if i_rd_dv is still 0 after TIMEOUT cycles, the FSM SHALL pulse o_err for one cycle, transmit nothing, and return to IDLE.
REQ-020 START: o_tx_serial SHALL be 0 and o_tx_active 1 for CLKS_PER_BIT cycles, beginning the cycle after capture.
REQ-021 DATA: the FSM SHALL send WIDTH bits LSB first, each held CLKS_PER_BIT cycles, using a bit index that counts 0..WIDTH-1 with no wrap.
REQ-022 STOP: o_tx_serial SHALL be 1 for CLKS_PER_BIT cycles; on the last cycle the FSM SHALL pulse o_tx_done, increment o_word_count, and return to IDLE.
REQ-023 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL reset to 0 on every state change, and SHALL expire at CLKS_PER_BIT-1.
REQ-024 o_word_count SHALL wrap from 16'hFFFF to 0 without a flag.
REQ-025 i_enable=0 SHALL block only new reads in IDLE; a frame already in RD_WAIT through STOP SHALL complete.
REQ-026 i_rd_dv outside RD_WAIT SHALL be ignored, and i_rd_data SHALL be sampled only in RD_WAIT.
REQ-027 o_rd_en SHALL never assert outside IDLE, so at most one read is outstanding.
REQ-028 After STOP, the earliest next o_rd_en SHALL come one cycle after returning to IDLE, giving at least one idle-high cycle between back-to-back frames.
REQ-029 o_tx_serial SHALL be registered and glitch-free.

Reset
REQ-030 Asserting i_rst SHALL immediately force: state IDLE, o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_err=0, o_rd_en=0, o_word_count=0, and the counters and shift register to 0.
REQ-031 If i_rst asserts mid-frame, the frame SHALL be abandoned with no o_tx_done pulse; the line SHALL return high at once.
REQ-032 After i_rst deasserts, operation SHALL resume on the first rising i_clk edge.

Verification (CLKS_PER_BIT=4, TIMEOUT=4)
REQ-033 Empty-to-frame: set i_empty=0 and i_rd_dv=1 one cycle after o_rd_en with data 8'hAB -> start bit 0, then bits 1,1,0,1,0,1,0,1, then stop bit 1, each 4 cycles; o_tx_done pulses once; o_word_count=1.
REQ-034 Back-to-back: supply data 8'h30..8'h33 with i_empty=0 throughout -> four frames in order, exactly four o_rd_en pulses, o_word_count=4, at least one idle-high cycle between frames.
REQ-035 Timeout: issue o_rd_en with i_rd_dv never asserted -> o_err pulses 4 cycles after RD_WAIT entry; o_tx_serial stays 1; o_word_count unchanged.
REQ-036 Enable gating: i_enable=0 with i_empty=0 -> no o_rd_en; set i_enable=1 -> o_rd_en within 1 cycle; drop i_enable mid-DATA -> the frame still completes.
REQ-037 Reset mid-frame: assert i_rst during DATA bit 3 -> o_tx_serial=1 and o_tx_active=0 immediately; no o_tx_done; o_word_count=0.
REQ-038 Stray dv: pulse i_rd_dv while in DATA -> the transmitted byte is unchanged.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// Drains words from a FIFO read port and sends each one as an 8N1-style UART frame.
// Each read is answered by a data-valid strobe within TIMEOUT cycles, or an error pulse is raised.
module fifo_uart_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_empty,
    output logic             o_rd_en,
    input  logic             i_rd_dv,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_tx_serial,
    output logic             o_tx_active,
    output logic             o_tx_done,
    output logic             o_err,
    output logic [15:0]      o_word_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [WIDTH-1:0]  shift_reg;

    // All outputs are registered so the serial line never glitches; the baud
    // counter is cleared on every transition so each bit starts a fresh period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            to_cnt       <= '0;
            shift_reg    <= '0;
            o_rd_en      <= 1'b0;
            o_tx_serial  <= 1'b1;
            o_tx_active  <= 1'b0;
            o_tx_done    <= 1'b0;
            o_err        <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_rd_en   <= 1'b0;
            o_tx_done <= 1'b0;
            o_err     <= 1'b0;

            case (state)
                S_IDLE: begin
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    to_cnt      <= '0;
                    o_tx_serial <= 1'b1;
                    o_tx_active <= 1'b0;
                    if (i_enable && !i_empty) begin
                        o_rd_en <= 1'b1;
                        state   <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (i_rd_dv) begin
                        shift_reg   <= i_rd_data;
                        to_cnt      <= '0;
                        o_tx_serial <= 1'b0;
                        o_tx_active <= 1'b1;
                        state       <= S_START;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt <= '0;
                        o_err  <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt    <= '0;
                        bit_idx     <= '0;
                        o_tx_serial <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state       <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                // Bits leave LSB first by shifting the captured word right.
                S_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            o_tx_serial <= 1'b1;
                            state       <= S_STOP;
                        end else begin
                            bit_idx     <= bit_idx + IDX_W'(1);
                            o_tx_serial <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt     <= '0;
                        o_tx_active  <= 1'b0;
                        o_tx_done    <= 1'b1;
                        o_word_count <= o_word_count + 16'd1;
                        state        <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    o_tx_serial <= 1'b1;
                    o_tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain with CLKS_PER_BIT=4, TIMEOUT=4: a cycle table for one
// frame followed by hand-written sequences for back-to-back, timeout, gating, reset and stray strobes.
module tb_fifo_uart_drain;

    logic        r_clk;
    logic        r_rst;
    logic        r_enable;
    logic        r_empty;
    logic        r_rd_dv;
    logic [7:0]  r_rd_data;
    logic        rd_en;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;
    logic        err;
    logic [15:0] word_count;

    int testsRun    = 0;
    int testsFailed = 0;
    int rdEnCount   = 0;
    int doneCount   = 0;
    int errCount    = 0;

    typedef struct {
        logic        enable;
        logic        empty;
        logic        rdDv;
        logic [7:0]  rdData;
        logic        expRdEn;
        logic        expSerial;
        logic        expActive;
        logic        expDone;
        logic        expErr;
        logic [15:0] expWordCount;
    } vec_t;

    localparam int NUM_VECS = 46;
    vec_t vecs[NUM_VECS];

    fifo_uart_drain #(
        .WIDTH(8),
        .CLKS_PER_BIT(4),
        .TIMEOUT(4)
    ) dut (
        .i_clk(r_clk),
        .i_rst(r_rst),
        .i_enable(r_enable),
        .i_empty(r_empty),
        .o_rd_en(rd_en),
        .i_rd_dv(r_rd_dv),
        .i_rd_data(r_rd_data),
        .o_tx_serial(tx_serial),
        .o_tx_active(tx_active),
        .o_tx_done(tx_done),
        .o_err(err),
        .o_word_count(word_count)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        r_enable  = v.enable;
        r_empty   = v.empty;
        r_rd_dv   = v.rdDv;
        r_rd_data = v.rdData;
    endtask

    // One cycle: outputs are sampled 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge r_clk);
        #1;
        if (rd_en)   rdEnCount++;
        if (tx_done) doneCount++;
        if (err)     errCount++;
    endtask

    task automatic doReset();
        r_rst     = 1'b1;
        r_enable  = 1'b0;
        r_empty   = 1'b1;
        r_rd_dv   = 1'b0;
        r_rd_data = 8'h00;
        #1;
        checkOutput("reset_serial", {31'b0, tx_serial}, 32'd1);
        checkOutput("reset_active", {31'b0, tx_active}, 32'd0);
        checkOutput("reset_flags", {29'b0, rd_en, tx_done, err}, 32'd0);
        checkOutput("reset_word_count", {16'b0, word_count}, 32'd0);
        stepCycle();
        stepCycle();
        r_rst = 1'b0;
    endtask

    // Waits for the read pulse, then answers it with a valid strobe one cycle later.
    // On return the start bit is the current sample.
    task automatic issueRead(input logic [7:0] data, input bit keepNotEmpty, input int maxWait, input string name);
        int waited;
        waited = 0;
        r_enable = 1'b1;
        while (!rd_en && waited < maxWait) begin
            stepCycle();
            waited++;
        end
        checkOutput({name, "_rd_en_seen"}, {31'b0, rd_en}, 32'd1);
        if (!rd_en) return;
        r_empty = keepNotEmpty ? 1'b0 : 1'b1;
        stepCycle();
        r_rd_dv   = 1'b1;
        r_rd_data = data;
        stepCycle();
        r_rd_dv   = 1'b0;
        r_rd_data = 8'h00;
    endtask

    // Decodes one frame by sampling the middle of each bit period.
    task automatic receiveFrame(input logic [7:0] expected, input string name, input int dropEnBit, input int strayDvBit);
        int waited;
        logic [7:0] rxByte;
        waited = 0;
        rxByte = 8'h00;
        while (tx_serial !== 1'b0 && waited < 10) begin
            stepCycle();
            waited++;
        end
        checkOutput({name, "_start_seen"}, {31'b0, tx_serial}, 32'd0);
        if (tx_serial !== 1'b0) return;
        checkOutput({name, "_start_active"}, {31'b0, tx_active}, 32'd1);
        stepCycle();
        stepCycle();
        checkOutput({name, "_start_mid"}, {31'b0, tx_serial}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) begin
                stepCycle();
                r_rd_dv   = 1'b0;
                r_rd_data = 8'h00;
            end
            rxByte[i] = tx_serial;
            if (i == dropEnBit) r_enable = 1'b0;
            if (i == strayDvBit) begin
                r_rd_dv   = 1'b1;
                r_rd_data = ~expected;
            end
        end
        checkOutput({name, "_byte"}, {24'b0, rxByte}, {24'b0, expected});
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            r_rd_dv   = 1'b0;
            r_rd_data = 8'h00;
        end
        checkOutput({name, "_stop"}, {30'b0, tx_serial, tx_active}, 32'd3);
        checkOutput({name, "_no_early_done"}, {31'b0, tx_done}, 32'd0);
        stepCycle();
        stepCycle();
        checkOutput({name, "_done"}, {29'b0, tx_done, tx_active, tx_serial}, 32'b101);
    endtask

    initial begin : main
        logic [7:0] frameData;
        int rdBase;
        int doneBase;
        int errBase;
        logic [7:0] d;

        r_rst = 1'b1;

        // Cycle table for one 8'hAB frame: read pulse, valid a cycle later, then 4 cycles per bit.
        frameData = 8'hAB;
        for (int k = 0; k < NUM_VECS; k++) begin
            vecs[k].enable       = 1'b1;
            vecs[k].empty        = 1'b1;
            vecs[k].rdDv         = 1'b0;
            vecs[k].rdData       = 8'h00;
            vecs[k].expRdEn      = (k == 1);
            vecs[k].expDone      = (k == 43);
            vecs[k].expErr       = 1'b0;
            vecs[k].expActive    = (k >= 3 && k <= 42);
            vecs[k].expWordCount = (k >= 43) ? 16'd1 : 16'd0;
            if (k >= 3 && k <= 6)       vecs[k].expSerial = 1'b0;
            else if (k >= 7 && k <= 38) vecs[k].expSerial = frameData[(k - 7) / 4];
            else                        vecs[k].expSerial = 1'b1;
        end
        vecs[0].enable = 1'b1;
        vecs[0].empty  = 1'b0;
        vecs[2].rdDv   = 1'b1;
        vecs[2].rdData = frameData;

        doReset();
        for (int k = 0; k < NUM_VECS; k++) begin
            stepCycle();
            checkOutput($sformatf("vec%0d_outputs", k),
                        {27'b0, rd_en, tx_serial, tx_active, tx_done, err},
                        {27'b0, vecs[k].expRdEn, vecs[k].expSerial, vecs[k].expActive,
                         vecs[k].expDone, vecs[k].expErr});
            checkOutput($sformatf("vec%0d_word_count", k), {16'b0, word_count}, {16'b0, vecs[k].expWordCount});
            applyStimulus(vecs[k]);
        end

        // Back-to-back frames with the FIFO kept non-empty until the last read.
        doReset();
        rdBase   = rdEnCount;
        doneBase = doneCount;
        r_empty  = 1'b0;
        for (int f = 0; f < 4; f++) begin
            d = 8'h30 + 8'(f);
            issueRead(d, f < 3, 3, $sformatf("b2b%0d", f));
            receiveFrame(d, $sformatf("b2b%0d", f), -1, -1);
        end
        for (int c = 0; c < 10; c++) stepCycle();
        checkOutput("b2b_rd_en_pulses", rdEnCount - rdBase, 32'd4);
        checkOutput("b2b_done_pulses", doneCount - doneBase, 32'd4);
        checkOutput("b2b_word_count", {16'b0, word_count}, 32'd4);

        // Read timeout: no valid strobe ever arrives.
        doReset();
        errBase  = errCount;
        rdBase   = rdEnCount;
        r_enable = 1'b1;
        r_empty  = 1'b0;
        for (int w = 0; w < 3 && !rd_en; w++) stepCycle();
        checkOutput("timeout_rd_en_seen", {31'b0, rd_en}, 32'd1);
        r_empty = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            stepCycle();
            checkOutput($sformatf("timeout_err_c%0d", j), {31'b0, err}, {31'b0, (j == 4)});
            checkOutput($sformatf("timeout_line_c%0d", j), {30'b0, tx_serial, tx_active}, 32'b10);
        end
        checkOutput("timeout_err_pulses", errCount - errBase, 32'd1);
        checkOutput("timeout_single_read", rdEnCount - rdBase, 32'd1);
        checkOutput("timeout_word_count", {16'b0, word_count}, 32'd0);

        // Enable gating, then drop enable in the middle of the data bits.
        doReset();
        rdBase   = rdEnCount;
        r_enable = 1'b0;
        r_empty  = 1'b0;
        for (int c = 0; c < 5; c++) stepCycle();
        checkOutput("gate_no_read", rdEnCount - rdBase, 32'd0);
        issueRead(8'h5C, 1'b0, 1, "gate");
        receiveFrame(8'h5C, "gate", 3, -1);
        checkOutput("gate_word_count", {16'b0, word_count}, 32'd1);

        // Stray valid strobe during the data bits must not disturb the byte.
        doReset();
        r_empty = 1'b0;
        issueRead(8'hA5, 1'b0, 3, "stray");
        receiveFrame(8'hA5, "stray", -1, 2);
        checkOutput("stray_word_count", {16'b0, word_count}, 32'd1);

        // Reset in the middle of data bit 3 (a zero bit of 8'hC3).
        doReset();
        doneBase = doneCount;
        r_empty  = 1'b0;
        issueRead(8'hC3, 1'b0, 3, "rst");
        for (int c = 0; c < 18; c++) stepCycle();
        checkOutput("rst_pre_line", {30'b0, tx_serial, tx_active}, 32'b01);
        #1;
        r_rst = 1'b1;
        #1;
        checkOutput("rst_line_high", {31'b0, tx_serial}, 32'd1);
        checkOutput("rst_active_low", {31'b0, tx_active}, 32'd0);
        stepCycle();
        r_rst = 1'b0;
        for (int c = 0; c < 50; c++) stepCycle();
        checkOutput("rst_no_done", doneCount - doneBase, 32'd0);
        checkOutput("rst_word_count", {16'b0, word_count}, 32'd0);
        checkOutput("rst_line_idle", {30'b0, tx_serial, tx_active}, 32'b10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
